// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with EX/WB forwarding, load-use stall and flush; ID_EX_STALL_CNT_EN adds a saturating stall counter
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 6,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              ex_wrt,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              wb_wrt,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [REG_AW-1:0] out_rd,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b
`ifdef ID_EX_STALL_CNT_EN
  , output logic [15:0]     stall_cnt
`endif
);
  logic hazard, capture;
  logic [DATA_W-1:0] fwd_a, fwd_b;
  always_comb begin
    hazard   = ex_wrt & ex_load & ((ex_rd == in_rs) | (ex_rd == in_rt));
    in_ready = flush | ((~out_valid | out_ready) & ~hazard);
    capture  = in_valid & in_ready & ~flush;
    fwd_a    = (ex_wrt & ~ex_load & (ex_rd == in_rs)) ? ex_result :
               (wb_wrt & (wb_rd == in_rs)) ? wb_data : rs_data;
    fwd_b    = (ex_wrt & ~ex_load & (ex_rd == in_rt)) ? ex_result :
               (wb_wrt & (wb_rd == in_rt)) ? wb_data : rt_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_rd    <= '0;
      out_a     <= '0;
      out_b     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_op    <= in_op;
      out_rd    <= in_rd;
      out_a     <= fwd_a;
      out_b     <= fwd_b;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`ifdef ID_EX_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (in_valid & hazard & ~flush & (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed-vector bench for id_ex_stage (stall_cnt checked when ID_EX_STALL_CNT_EN is defined)
module tb_id_ex_stage;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [3:0] in_op = '0;
  logic [5:0] in_rd = '0, in_rs = '0, in_rt = '0, ex_rd = '0, wb_rd = '0, out_rd;
  logic [31:0] rs_data = '0, rt_data = '0, ex_result = '0, wb_data = '0;
  logic ex_wrt = 1'b0, ex_load = 1'b0, wb_wrt = 1'b0, flush = 1'b0;
  logic out_valid, out_ready = 1'b0;
  logic [3:0] out_op;
  logic [31:0] out_a, out_b;
  int vecs = 0, errs = 0;
`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .rs_data(rs_data), .rt_data(rt_data),
    .ex_wrt(ex_wrt), .ex_load(ex_load), .ex_rd(ex_rd), .ex_result(ex_result),
    .wb_wrt(wb_wrt), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_rd(out_rd), .out_a(out_a), .out_b(out_b)
`ifdef ID_EX_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_op", 32'(out_op), 32'd0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    chk("rst_a", out_a, 32'd0);
    chk("rst_b", out_b, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
`ifdef ID_EX_STALL_CNT_EN
    chk("rst_stall", 32'(stall_cnt), 32'd0);
`endif
    // single op
    in_valid = 1; in_op = 4'h5; in_rd = 3; in_rs = 1; in_rt = 2;
    rs_data = 7; rt_data = 9; out_ready = 1;
    tick();
    in_valid = 0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_op", 32'(out_op), 32'h5);
    chk("single_rd", 32'(out_rd), 32'd3);
    chk("single_a", out_a, 32'd7);
    chk("single_b", out_b, 32'd9);
    tick();
    chk("single_drain", 32'(out_valid), 32'd0);
    chk("single_keep_a", out_a, 32'd7);
    // EX forward
    in_valid = 1; in_rs = 21; in_rt = 2; ex_wrt = 1; ex_load = 0; ex_rd = 21;
    ex_result = 32'h10; rs_data = 5; rt_data = 9;
    tick();
    in_valid = 0; ex_wrt = 0;
    chk("exfwd_a", out_a, 32'h10);
    chk("exfwd_b", out_b, 32'd9);
    // EX beats WB, then WB alone
    in_valid = 1; in_rs = 1; in_rt = 20; ex_rd = 20; wb_rd = 20;
    ex_result = 1; wb_data = 2; ex_wrt = 1; wb_wrt = 1; rt_data = 3;
    tick();
    chk("prio_ex_b", out_b, 32'd1);
    ex_wrt = 0;
    tick();
    chk("prio_wb_valid", 32'(out_valid), 32'd1);
    chk("prio_wb_b", out_b, 32'd2);
    in_valid = 0; wb_wrt = 0;
    tick();
    chk("prio_drain", 32'(out_valid), 32'd0);
    // load-use stall
    in_valid = 1; in_rd = 9; in_rs = 8; in_rt = 2; rs_data = 32'h44;
    ex_wrt = 1; ex_load = 1; ex_rd = 8;
    #1;
    chk("lu_ready", 32'(in_ready), 32'd0);
    tick();
    chk("lu_bubble", 32'(out_valid), 32'd0);
`ifdef ID_EX_STALL_CNT_EN
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
`endif
    ex_wrt = 0; ex_load = 0; wb_wrt = 1; wb_rd = 8; wb_data = 32'h55;
    #1;
    chk("lu_ready_after", 32'(in_ready), 32'd1);
    tick();
    chk("lu_cap_valid", 32'(out_valid), 32'd1);
    chk("lu_cap_a", out_a, 32'h55);
    chk("lu_cap_rd", 32'(out_rd), 32'd9);
`ifdef ID_EX_STALL_CNT_EN
    chk("lu_stall_hold", 32'(stall_cnt), 32'd1);
`endif
    // backpressure then flush
    wb_wrt = 0; in_rd = 12; rs_data = 1; out_ready = 0;
    #1;
    chk("bp_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_a", out_a, 32'h55);
      chk("bp_rd", 32'(out_rd), 32'd9);
      chk("bp_ready_hold", 32'(in_ready), 32'd0);
    end
    flush = 1;
    #1;
    chk("flush_ready", 32'(in_ready), 32'd1);
    tick();
    flush = 0; in_valid = 0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_nocap_rd", 32'(out_rd), 32'd9);
    // back-to-back
    out_ready = 1; in_rs = 1; in_rt = 2;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_rd = 6'(i + 1); rs_data = 32'(100 + i); rt_data = 32'(200 + i);
      tick();
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_rd", 32'(out_rd), 32'(i + 1));
      chk("b2b_a", out_a, 32'(100 + i));
      chk("b2b_b", out_b, 32'(200 + i));
    end
    in_valid = 0;
    tick();
    chk("b2b_drain", 32'(out_valid), 32'd0);
    // register 0 compared like any other
    ex_wrt = 1; ex_load = 1; ex_rd = 0; in_rs = 0; in_rt = 5; in_valid = 1;
    #1;
    chk("r0_hazard", 32'(in_ready), 32'd0);
    ex_wrt = 0; ex_load = 0; in_rd = 7;
    // reset mid-hold
    tick();
    in_valid = 0; out_ready = 0;
    chk("hold_pre_rst", 32'(out_valid), 32'd1);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    chk("rst_hold_rd", 32'(out_rd), 32'd0);
`ifdef ID_EX_STALL_CNT_EN
    chk("rst_stall_clr", 32'(stall_cnt), 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
